// File: rtl/ternary_exec_monitor.sv
// ternary_exec_monitor
//   Watches the ternary CPU program counter and controller state. Declares a
//   halt when the PC stays frozen for STALL_CYCLES consecutive fetch samples,
//   or a timeout after TIMEOUT_CYCLES run cycles, then converts the captured
//   balanced-ternary PC to a signed integer with a trit-serial Horner engine.
//
//   Trit codes: 2'b10 = -1, 2'b00 = 0, 2'b01 = +1, 2'b11 = non-legal.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low
//   start        single-cycle pulse, begins monitoring (from IDLE or FIN)
//   pc           CPU program counter, trit i at pc[2i+1:2i]
//   cpu_state    CPU controller state
//   busy         high in RUN or CONV
//   done         halt detected (sticky until start/reset)
//   timeout      run-cycle limit reached (sticky until start/reset)
//   pc_int       signed integer value of the PC snapshot
//   pc_int_valid pc_int is final
//   pc_invalid   snapshot contained a non-legal trit code
//   cycle_count  RUN cycles since start
//   instr_count  PC changes observed in RUN
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RUN   | sampling pc/cpu_state, counting, looking for halt or timeout
// CONV  | Horner conversion of the snapshot, one trit per cycle, MS trit first
// FIN   | results held, start re-arms monitoring
module ternary_exec_monitor #(
   parameter int TRITS          = 9,
   parameter int STATE_W        = 3,
   parameter int FETCH_STATE    = 0,
   parameter int STALL_CYCLES   = 5,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 32,
   parameter int INT_W          = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2*TRITS-1:0]      pc,
   input  logic [STATE_W-1:0]      cpu_state,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic signed [INT_W-1:0] pc_int,
   output logic                    pc_int_valid,
   output logic                    pc_invalid,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [CNT_W-1:0]        instr_count
);

   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   localparam int IDX_W   = (TRITS > 1) ? $clog2(TRITS) : 1;

   localparam logic [1:0] TRIT_NEG = 2'b10;
   localparam logic [1:0] TRIT_POS = 2'b01;
   localparam logic [1:0] TRIT_ZRO = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CONV,
      S_FIN
   } state_t;

   state_t                    state, state_nxt;
   logic                      first;
   logic [2*TRITS-1:0]        prev_pc;
   logic [2*TRITS-1:0]        snap_pc;
   logic [STALL_W-1:0]        stall_cnt;
   logic [STALL_W-1:0]        stall_inc;
   logic [IDX_W-1:0]          trit_idx;
   logic signed [INT_W-1:0]   acc;
   logic signed [INT_W-1:0]   acc_nxt;
   logic signed [INT_W-1:0]   trit_val;
   logic [1:0]                trit_code;
   logic                      trit_bad;
   logic [CNT_W-1:0]          cycle_inc;
   logic                      pc_same;
   logic                      in_fetch;
   logic                      halt_hit;
   logic                      tmo_hit;

   always_comb begin
      cycle_inc = cycle_count + 1'b1;
      stall_inc = stall_cnt + 1'b1;
      pc_same   = (pc == prev_pc);
      in_fetch  = (cpu_state == STATE_W'(FETCH_STATE));
      halt_hit  = !first && pc_same && in_fetch && (stall_inc == STALL_W'(STALL_CYCLES));
      tmo_hit   = (cycle_inc == CNT_W'(TIMEOUT_CYCLES));

      trit_code = snap_pc[2*trit_idx +: 2];
      trit_bad  = 1'b0;
      trit_val  = '0;
      case (trit_code)
         TRIT_POS: trit_val = INT_W'(1);
         TRIT_NEG: trit_val = '1;
         TRIT_ZRO: trit_val = '0;
         default:  trit_bad = 1'b1;
      endcase
      acc_nxt = (acc <<< 1) + acc + trit_val;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_FIN: if (start) state_nxt = S_RUN;
         S_RUN:         if (halt_hit || tmo_hit) state_nxt = S_CONV;
         S_CONV:        if (trit_idx == '0) state_nxt = S_FIN;
         default:       state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         first        <= 1'b0;
         prev_pc      <= '0;
         snap_pc      <= '0;
         stall_cnt    <= '0;
         trit_idx     <= '0;
         acc          <= '0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         pc_int       <= '0;
         pc_int_valid <= 1'b0;
         pc_invalid   <= 1'b0;
         cycle_count  <= '0;
         instr_count  <= '0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  first        <= 1'b1;
                  stall_cnt    <= '0;
                  done         <= 1'b0;
                  timeout      <= 1'b0;
                  pc_int       <= '0;
                  pc_int_valid <= 1'b0;
                  pc_invalid   <= 1'b0;
                  cycle_count  <= '0;
                  instr_count  <= '0;
               end
            end
            S_RUN: begin
               cycle_count <= cycle_inc;
               if (first) begin
                  first   <= 1'b0;
                  prev_pc <= pc;
               end else if (!pc_same) begin
                  instr_count <= instr_count + 1'b1;
                  stall_cnt   <= '0;
                  prev_pc     <= pc;
               end else if (in_fetch) begin
                  stall_cnt <= stall_inc;
               end else begin
                  stall_cnt <= '0;
               end
               // halt has priority over a timeout landing on the same cycle
               if (halt_hit || tmo_hit) begin
                  done     <= halt_hit;
                  timeout  <= !halt_hit;
                  snap_pc  <= pc;
                  acc      <= '0;
                  trit_idx <= IDX_W'(TRITS - 1);
               end
            end
            S_CONV: begin
               acc <= acc_nxt;
               if (trit_bad) pc_invalid <= 1'b1;
               if (trit_idx == '0) begin
                  pc_int       <= acc_nxt;
                  pc_int_valid <= 1'b1;
               end else begin
                  trit_idx <= trit_idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == S_RUN) || (state == S_CONV);

endmodule

// File: tb/tb_ternary_exec_monitor.sv
// Self-checking bench for ternary_exec_monitor. Instance u_dut uses default
// parameters; u_dut_b uses TIMEOUT_CYCLES=6 for the halt/timeout collision.
module tb_ternary_exec_monitor;
   localparam int TRITS = 9;
   localparam logic [1:0] T_NEG = 2'b10;
   localparam logic [1:0] T_POS = 2'b01;
   localparam logic [1:0] T_BAD = 2'b11;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                  reset = 1'b0;
   logic                  start = 1'b0;
   logic [2*TRITS-1:0]    pc = '0;
   logic [2:0]            cpu_state = '0;
   logic                  busy, done, timeout, pc_int_valid, pc_invalid;
   logic signed [15:0]    pc_int;
   logic [31:0]           cycle_count, instr_count;

   logic                  start_b = 1'b0;
   logic [2*TRITS-1:0]    pc_b = '0;
   logic [2:0]            cpu_state_b = '0;
   logic                  busy_b, done_b, timeout_b, pc_int_valid_b, pc_invalid_b;
   logic signed [15:0]    pc_int_b;
   logic [31:0]           cycle_count_b, instr_count_b;

   int n_asserts = 0;
   int n_fail    = 0;

   ternary_exec_monitor u_dut (
      .clock(clock), .reset(reset), .start(start), .pc(pc), .cpu_state(cpu_state),
      .busy(busy), .done(done), .timeout(timeout), .pc_int(pc_int),
      .pc_int_valid(pc_int_valid), .pc_invalid(pc_invalid),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   ternary_exec_monitor #(.TIMEOUT_CYCLES(6), .STALL_CYCLES(5)) u_dut_b (
      .clock(clock), .reset(reset), .start(start_b), .pc(pc_b), .cpu_state(cpu_state_b),
      .busy(busy_b), .done(done_b), .timeout(timeout_b), .pc_int(pc_int_b),
      .pc_int_valid(pc_int_valid_b), .pc_invalid(pc_invalid_b),
      .cycle_count(cycle_count_b), .instr_count(instr_count_b)
   );

   // integer -> balanced ternary, least-significant trit first
   function automatic logic [2*TRITS-1:0] enc(input int v);
      logic [2*TRITS-1:0] p;
      int x;
      int r;
      p = '0;
      x = v;
      for (int i = 0; i < TRITS; i++) begin
         r = ((x % 3) + 3) % 3;
         if (r == 1) begin
            p[2*i +: 2] = T_POS;
            x = (x - 1) / 3;
         end else if (r == 2) begin
            p[2*i +: 2] = T_NEG;
            x = (x + 1) / 3;
         end else begin
            x = x / 3;
         end
      end
      return p;
   endfunction

   // weighted sum of trits; non-legal codes count as 0
   function automatic int dec(input logic [2*TRITS-1:0] p);
      int s;
      int w;
      logic [1:0] c;
      s = 0;
      w = 1;
      for (int i = 0; i < TRITS; i++) begin
         c = p[2*i +: 2];
         if (c == T_POS) s = s + w;
         else if (c == T_NEG) s = s - w;
         w = w * 3;
      end
      return s;
   endfunction

   function automatic int has_bad(input logic [2*TRITS-1:0] p);
      logic [1:0] c;
      int b;
      b = 0;
      for (int i = 0; i < TRITS; i++) begin
         c = p[2*i +: 2];
         if (c == T_BAD) b = 1;
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // checks conversion results after a halt/timeout seen on the last step
   task automatic check_conv(input string tag, input logic [2*TRITS-1:0] p);
      for (int k = 0; k < TRITS; k++) begin
         if (k == TRITS - 1) chk({tag, " valid_early"}, pc_int_valid, 0);
         step();
      end
      chk({tag, " valid"}, pc_int_valid, 1);
      chk({tag, " pc_int"}, pc_int, dec(p));
      chk({tag, " pc_invalid"}, pc_invalid, has_bad(p));
      chk({tag, " busy_fin"}, busy, 0);
   endtask

   task automatic halt_on(input string tag, input logic [2*TRITS-1:0] p0, input logic [2*TRITS-1:0] p);
      int n_hold;
      int exp_instr;
      exp_instr = (p0 != p) ? 1 : 0;
      n_hold    = (p0 != p) ? 5 : 4;
      do_start();
      chk({tag, " clr_cycles"}, cycle_count, 0);
      chk({tag, " clr_valid"}, pc_int_valid, 0);
      chk({tag, " clr_done"}, done, 0);
      cpu_state = 3'd0;
      pc = p0;
      step();
      pc = p;
      step();
      for (int k = 0; k < n_hold; k++) begin
         if (k == n_hold - 1) chk({tag, " done_early"}, done, 0);
         step();
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " timeout"}, timeout, 0);
      chk({tag, " instr"}, instr_count, exp_instr);
      chk({tag, " cycles"}, cycle_count, 2 + n_hold);
      check_conv(tag, p);
   endtask

   initial begin
      logic [2*TRITS-1:0] p;
      logic [2*TRITS-1:0] prev;
      logic [2*TRITS-1:0] vals [3];
      int n, instr, run, seen, halt_e, tmo_e;

      // reset state
      repeat (2) step();
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst timeout", timeout, 0);
      chk("rst pc_int", pc_int, 0);
      chk("rst valid", pc_int_valid, 0);
      chk("rst invalid", pc_invalid, 0);
      chk("rst cycles", cycle_count, 0);
      chk("rst instr", instr_count, 0);
      reset = 1'b1;
      step();

      // halt after pc 0,1,2,3 then frozen at 3; start pulsed mid-RUN is ignored
      do_start();
      chk("h1 busy", busy, 1);
      cpu_state = 3'd0;
      for (int v = 0; v < 4; v++) begin
         pc = enc(v);
         step();
      end
      for (int k = 0; k < 5; k++) begin
         start = (k == 1);
         if (k == 4) chk("h1 done_early", done, 0);
         step();
      end
      start = 1'b0;
      chk("h1 done", done, 1);
      chk("h1 timeout", timeout, 0);
      chk("h1 instr", instr_count, 3);
      chk("h1 cycles", cycle_count, 9);
      check_conv("h1", enc(3));
      chk("h1 pc_int_3", pc_int, 3);

      // negative and extreme PCs (restart from FIN each time)
      halt_on("neg", enc(0), enc(-4));
      halt_on("allpos", enc(9841), enc(9841));
      chk("allpos val", pc_int, 9841);
      halt_on("allneg", enc(-9841), enc(-9841));
      chk("allneg val", pc_int, -9841);

      // non-legal code in trit 4 contributes 0
      p = enc(86);
      p[9:8] = T_BAD;
      halt_on("badtrit", enc(2), p);
      chk("badtrit val", pc_int, 5);

      // stall qualification: fetch/non-fetch alternate, only timeout can fire
      do_start();
      pc = enc(7);
      seen = 0;
      for (int k = 0; k < 1000; k++) begin
         cpu_state = (k % 2 == 1) ? 3'd2 : 3'd0;
         if (done || timeout) seen = 1;
         step();
      end
      chk("sq early_event", seen, 0);
      chk("sq timeout", timeout, 1);
      chk("sq done", done, 0);
      chk("sq cycles", cycle_count, 1000);
      chk("sq instr", instr_count, 0);
      check_conv("sq", enc(7));

      // simultaneous halt and timeout on the short-timeout instance
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      pc_b = enc(5);
      cpu_state_b = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) chk("sim done_early", done_b, 0);
         step();
      end
      chk("sim done", done_b, 1);
      chk("sim timeout", timeout_b, 0);
      chk("sim cycles", cycle_count_b, 6);

      // reset asserted three cycles into CONV
      do_start();
      pc = enc(-20);
      cpu_state = 3'd0;
      repeat (6) step();
      chk("rc done", done, 1);
      repeat (3) step();
      chk("rc busy_conv", busy, 1);
      reset = 1'b0;
      #1;
      chk("rc busy", busy, 0);
      chk("rc done0", done, 0);
      chk("rc pc_int", pc_int, 0);
      chk("rc valid", pc_int_valid, 0);
      chk("rc cycles", cycle_count, 0);
      step();
      reset = 1'b1;
      step();
      chk("rc idle", busy, 0);
      halt_on("rc restart", enc(11), enc(-13));

      // randomized runs against the reference model
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 3; j++) vals[j] = enc(int'($urandom_range(0, 19682)) - 9841);
         do_start();
         n = 0; instr = 0; run = 0; prev = '0; p = vals[0];
         halt_e = 0; tmo_e = 0;
         while (!halt_e && !tmo_e && n < 1000) begin
            if ($urandom_range(0, 3) == 0) p = vals[$urandom_range(0, 2)];
            pc = p;
            cpu_state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            step();
            n++;
            if (n == 1) prev = p;
            else if (p != prev) begin
               instr++;
               run = 0;
               prev = p;
            end else if (cpu_state == 3'd0) run++;
            else run = 0;
            halt_e = (run == 5) ? 1 : 0;
            tmo_e  = (!halt_e && n == 1000) ? 1 : 0;
            chk("rnd done", done, halt_e);
            chk("rnd timeout", timeout, tmo_e);
         end
         chk("rnd cycles", cycle_count, n);
         chk("rnd instr", instr_count, instr);
         check_conv("rnd", p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
